// File: rtl/if_fetch_queue.sv
//==============================================================================
// Module  : if_fetch_queue
// Brief   : Decoupled instruction fetch with a FQ_DEPTH-entry prefetch queue;
//           optional IFQ_PERF_EN adds delivered/discarded counters.
// Revision: 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0]     perf_delivered,
    output logic [31:0]     perf_discarded
`endif
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam logic [CW:0]     C_DEPTH = (CW + 1)'(FQ_DEPTH);
    localparam logic [XLEN-1:0] C_STEP  = XLEN'(4);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [XLEN-1:0] pc_mem_q [FQ_DEPTH];
    logic [XLEN-1:0] pc_mem_d [FQ_DEPTH];
    logic [XLEN-1:0] instr_mem_q [FQ_DEPTH];
    logic [XLEN-1:0] instr_mem_d [FQ_DEPTH];

    logic [CW:0]     w_used;
    logic            w_fire;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic [XLEN-1:0] w_target;

    // Credit covers both queued entries and requests still in flight.
    assign w_used         = {1'b0, count_q} + {1'b0, outstanding_q};
    assign imem_req_valid = !rst && (w_used < C_DEPTH) && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign w_fire         = imem_req_valid && imem_req_ready;
    assign w_drop         = imem_resp_valid && (redirect_valid || (discard_q != '0));
    assign w_push         = imem_resp_valid && !w_drop;
    assign w_pop          = id_valid && id_ready && !redirect_valid;
    assign w_target       = redirect_pc & ~XLEN'(3);

    assign id_valid = (count_q != '0);
    assign id_pc    = id_valid ? pc_mem_q[head_q]    : '0;
    assign id_instr = id_valid ? instr_mem_q[head_q] : '0;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q + CW'(w_fire) - CW'(imem_resp_valid);
        discard_d     = discard_q;
        head_d        = head_q;
        tail_d        = tail_q;
        pc_mem_d      = pc_mem_q;
        instr_mem_d   = instr_mem_q;
        if (redirect_valid) begin
            // Everything still in flight after this cycle is stale.
            fetch_pc_d = w_target;
            resp_pc_d  = w_target;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            discard_d  = outstanding_q - CW'(imem_resp_valid);
        end else begin
            if (w_fire) begin
                fetch_pc_d = fetch_pc_q + C_STEP;
            end
            if (imem_resp_valid && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (w_push) begin
                pc_mem_d[tail_q]    = resp_pc_q;
                instr_mem_d[tail_q] = imem_resp_data;
                tail_d              = tail_q + PW'(1);
                resp_pc_d           = resp_pc_q + C_STEP;
            end
            if (w_pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            pc_mem_q      <= '{default: '0};
            instr_mem_q   <= '{default: '0};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            pc_mem_q      <= pc_mem_d;
            instr_mem_q   <= instr_mem_d;
        end
    end

`ifdef IFQ_PERF_EN
    logic [31:0] perf_delivered_q, perf_delivered_d;
    logic [31:0] perf_discarded_q, perf_discarded_d;

    always_comb begin
        perf_delivered_d = perf_delivered_q + 32'(id_valid && id_ready);
        perf_discarded_d = perf_discarded_q + 32'(w_drop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_delivered_q <= '0;
            perf_discarded_q <= '0;
        end else begin
            perf_delivered_q <= perf_delivered_d;
            perf_discarded_q <= perf_discarded_d;
        end
    end

    assign perf_delivered = perf_delivered_q;
    assign perf_discarded = perf_discarded_q;
`else
    // Counters are absent in this build.
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
//==============================================================================
// Module  : tb_if_fetch_queue
// Brief   : Randomized scoreboard bench for if_fetch_queue with an in-order
//           variable-latency memory model.
// Revision: 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_if_fetch_queue;

    localparam int          XLEN   = 32;
    localparam int          D      = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
`ifdef IFQ_PERF_EN
    logic [31:0] perf_delivered;
    logic [31:0] perf_discarded;
`endif

    if_fetch_queue #(.XLEN(XLEN), .RESET_PC(RST_PC), .FQ_DEPTH(D)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
        .id_instr        (id_instr)
`ifdef IFQ_PERF_EN
        ,
        .perf_delivered  (perf_delivered),
        .perf_discarded  (perf_discarded)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    req_t        pend[$];   // requests accepted by the memory, oldest first
    ent_t        expq[$];   // expected decode stream currently held in the queue
    int          total;
    int          bad;
    int          epoch;
    int          cyc;
    int          last_due;
    logic [31:0] m_fetch;
    logic [31:0] m_resp;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake toward decode consumes the oldest expected entry.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (!rst && id_valid && id_ready && !redirect_valid) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL deliver: got pc %h expected no entry", id_pc);
                end else begin
                    e = expq.pop_front();
                    check("id_pc", id_pc, e.pc);
                    check("id_instr", id_instr, e.instr);
                end
            end
        end
    end

    task automatic clear_model();
        pend.delete();
        expq.delete();
        epoch++;
        last_due = 0;
        m_fetch  = RST_PC;
        m_resp   = RST_PC;
    endtask

    task automatic zero_inputs();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        id_ready        = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        check({tag, "_id_valid"}, {31'b0, id_valid}, 32'd0);
        check({tag, "_id_pc"}, id_pc, 32'd0);
        check({tag, "_id_instr"}, id_instr, 32'd0);
        check({tag, "_req_addr"}, imem_req_addr, RST_PC);
`ifdef IFQ_PERF_EN
        check({tag, "_perf_del"}, perf_delivered, 32'd0);
        check({tag, "_perf_dis"}, perf_discarded, 32'd0);
`endif
    endtask

    // Asynchronous reset in the middle of a cycle, away from any clock edge.
    task automatic mid_reset();
        @(posedge clk);
        #3;
        zero_inputs();
        rst = 1'b1;
        #1;
        reset_checks("async_rst");
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cycle(input int p_redir, input int p_idr, input int p_mrdy,
                         input int lat_min, input int lat_max);
        logic exp_rv;
        req_t r;
        int   due;
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = ($urandom_range(99) < p_redir);
        redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF))
                                                  : ($urandom() & 32'h0000_0FFF);
        id_ready       = ($urandom_range(99) < p_idr);
        imem_req_ready = ($urandom_range(99) < p_mrdy);
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memf(pend[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom();
        end
        #1;
        exp_rv = ((expq.size() + pend.size()) < D) && !redirect_valid;
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        check("id_valid", {31'b0, id_valid}, {31'b0, (expq.size() != 0)});
        if (exp_rv) check("req_addr", imem_req_addr, m_fetch);
        if (expq.size() == 0) check("id_pc_empty", id_pc, 32'd0);
        @(negedge clk);
        #1;
        if (imem_resp_valid) begin
            r = pend.pop_front();
            if (!redirect_valid && r.epoch == epoch) begin
                expq.push_back('{pc: m_resp, instr: memf(m_resp)});
                m_resp = m_resp + 32'd4;
            end
        end
        if (redirect_valid) begin
            expq.delete();
            epoch++;
            m_fetch = redirect_pc & 32'hFFFF_FFFC;
            m_resp  = m_fetch;
        end else if (exp_rv && imem_req_ready) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{addr: imem_req_addr, epoch: epoch, due: due});
            m_fetch = m_fetch + 32'd4;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        epoch = 0;
        cyc   = 0;
        rst   = 1'b1;
        zero_inputs();
        clear_model();
        #12;
        reset_checks("reset");
        @(negedge clk);
        rst = 1'b0;

        // Streaming: latency 1, decode always ready, no redirects.
        repeat (40) cycle(0, 100, 100, 1, 1);
        // Backpressure: queue fills and requests stop at the credit limit.
        repeat (20) cycle(0, 0, 100, 1, 2);
        repeat (20) cycle(0, 100, 100, 1, 2);
        // Memory stalls with occasional redirects (unaligned targets included).
        repeat (30) cycle(10, 80, 0, 1, 3);
        // Long latency with redirects landing on in-flight responses.
        repeat (200) cycle(15, 80, 100, 3, 3);
        // Fully random traffic.
        repeat (600) cycle(8, 70, 70, 1, 4);
        mid_reset();
        repeat (300) cycle(8, 60, 80, 1, 4);
        mid_reset();
        repeat (60) cycle(0, 100, 100, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised successor to the single-register fetch stage: decoupled instruction fetch with a prefetch queue between instruction memory and decode.
- Issues in-order, pipelined requests to a valid/ready instruction memory that has variable response latency.
- Buffers up to FQ_DEPTH instructions with their PCs and hands them to decode over a valid/ready handshake.
- Handles branch redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
- XLEN, 32: PC and instruction width.
- RESET_PC, 32'h0000_0000: fetch address after reset.
- FQ_DEPTH, 4: queue entries. Power of 2, at least 2. Also the maximum number of outstanding memory requests.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_resp_valid  in  1  response data valid; responses return in request order
- imem_resp_data  in  XLEN  instruction word
- redirect_valid  in  1  branch taken / flush, one-cycle pulse
- redirect_pc  in  XLEN  new fetch target
- id_valid  out  1  head entry valid toward decode
- id_ready  in  1  decode accepts head entry
- id_pc  out  XLEN  PC of head entry
- id_instr  out  XLEN  instruction of head entry

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high.
- Reset state:
  - fetch_pc = resp_pc = RESET_PC.
  - Queue count = 0, outstanding = 0, discard_cnt = 0.
  - imem_req_valid = 0, id_valid = 0.
  - id_pc and id_instr = 0 while the queue is empty.
- Credit rule: imem_req_valid = (count + outstanding < FQ_DEPTH) && !redirect_valid.
  - imem_req_addr = fetch_pc.
  - Request fires on valid && ready; then fetch_pc += 4 (wraps modulo 2^XLEN) and outstanding += 1.
  - The queue can never overflow.
- Response handling: each imem_resp_valid decrements outstanding.
  - If discard_cnt > 0: the response is dropped and discard_cnt -= 1.
  - Otherwise {resp_pc, imem_resp_data} is written at the queue tail and resp_pc += 4.
- Queue behaviour:
  - Registered circular buffer. A response written in cycle M makes id_valid = 1 from cycle M+1.
  - Minimum fetch latency: request in cycle N, response in N+1, id_valid in N+2.
  - id_valid = (count != 0). id_pc and id_instr come from the head entry.
  - Pop on id_valid && id_ready.
  - Simultaneous push and pop is legal at any count, including full.
  - Pointers wrap modulo FQ_DEPTH.
- Redirect (highest priority, same cycle):
  - redirect_pc[1:0] is forced to 0.
  - fetch_pc and resp_pc load redirect_pc; count is cleared, so id_valid = 0 the next cycle.
  - No request is issued that cycle.
  - discard_cnt = outstanding after this cycle's response is accounted for: a response arriving in the redirect cycle is dropped and is not counted in discard_cnt.
  - A pop or push in the same cycle is ignored.
  - Back-to-back redirects are legal; the last one wins, and discard_cnt is recomputed each time.
- Backpressure:
  - With id_ready = 0 the queue fills, and requests stop once count + outstanding = FQ_DEPTH.
  - imem_req_ready = 0 holds imem_req_valid and imem_req_addr stable until accepted, unless a redirect occurs.
- Reset mid-operation: all state returns to reset values immediately and in-flight requests are forgotten. The instruction memory shares rst and must drop its pending responses.

Optional Feature:
- Macro: IFQ_PERF_EN.
- When defined, adds outputs perf_delivered (32-bit, counts id_valid && id_ready) and perf_discarded (32-bit, counts dropped responses, including those dropped in a redirect cycle).
  - Both reset to 0 and wrap on overflow.
- When undefined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, memory latency 1, id_ready = 1 → addrs 0x0, 0x4, 0x8… issued every cycle; id_pc sequence 0x0, 0x4… starting 2 cycles after the first request, with id_instr matching memory.
- id_ready = 0, FQ_DEPTH = 4 → exactly 4 requests issued, then imem_req_valid = 0; count holds at 4.
  - Raise id_ready → pops resume and exactly one new request is issued per pop.
- Latency 3 with 3 requests outstanding; redirect_valid with redirect_pc = 0x100 → next cycle id_valid = 0.
  - The 3 stale responses are dropped.
  - First delivered id_pc = 0x100, with id_instr = mem[0x100].
- Redirect in the same cycle as a response and a pop → that response is dropped, the queue is empty next cycle, and discard_cnt equals the remaining outstanding requests.
- imem_req_ready low for 5 cycles → imem_req_addr stable at 0x8 and no fetch_pc advance; redirect_pc = 0x203 → address becomes 0x200.
- Reset asserted asynchronously mid-burst → outputs clear without waiting for a clock edge; after release, fetch restarts at RESET_PC. With IFQ_PERF_EN, both counters read 0.
